// File: rtl/pll_supervisor.sv
// PLL supervisor for a PLLVR in dynamic-divider mode.
// Sequences the PLL reset, drives the divider selects, qualifies LOCK with a
// stability window, a timeout and bounded retry, and accepts run-time
// divider changes through a cfg_req/cfg_ack handshake.
module pll_supervisor #(
  parameter int SEL_W        = 6,
  parameter int IDIV_INIT    = 6,
  parameter int FBDIV_INIT   = 12,
  parameter int ODIV_INIT    = 8,
  parameter int INV_SEL      = 1,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             cfg_req,
  input  logic [SEL_W-1:0] cfg_idiv,
  input  logic [SEL_W-1:0] cfg_fbdiv,
  input  logic [SEL_W-1:0] cfg_odiv,
  output logic             cfg_ack,
  output logic             pll_reset,
  output logic [SEL_W-1:0] pll_idsel,
  output logic [SEL_W-1:0] pll_fbdsel,
  output logic [SEL_W-1:0] pll_odsel,
  output logic             pll_ready,
  output logic             user_rst_n,
  output logic             lock_err,
  output logic [1:0]       retry_cnt,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_READY      = 3'd3,
    ST_FAIL       = 3'd4
  } state_t;

  // One shared counter serves every timed state, so size it for the longest.
  localparam int CNT_MAX_A = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int CNT_MAX   = (CNT_MAX_A > RST_CYCLES) ? CNT_MAX_A : RST_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);

  localparam logic [SEL_W-1:0] IDIV_RST  = SEL_W'(IDIV_INIT);
  localparam logic [SEL_W-1:0] FBDIV_RST = SEL_W'(FBDIV_INIT);
  localparam logic [SEL_W-1:0] ODIV_RST  = SEL_W'(ODIV_INIT);

  // PLLVR dynamic selects take the one's complement of the divider code.
  function automatic logic [SEL_W-1:0] encode_sel(input logic [SEL_W-1:0] code);
    return (INV_SEL != 0) ? ~code : code;
  endfunction

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [1:0]         lock_sync_reg;
  logic               lock_s;
  logic [1:0]         retry_reg, retry_next;
  logic [2:0]         retry_inc;
  logic               lock_err_reg, lock_err_next;
  logic               ack_next;
  logic               capture;
  logic [SEL_W-1:0]   idiv_reg, fbdiv_reg, odiv_reg;
  logic [SEL_W-1:0]   idsel_reg, fbdsel_reg, odsel_reg;
  logic               pll_reset_reg, pll_ready_reg, user_rst_n_reg, cfg_ack_reg;

  assign lock_s    = lock_sync_reg[1];
  assign retry_inc = {1'b0, retry_reg} + 3'd1;

  // Two-flop synchroniser for the asynchronous LOCK pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_sync_reg <= 2'b00;
    else        lock_sync_reg <= {lock_sync_reg[0], pll_lock};
  end

  // State, counter, retry bookkeeping and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_RESET_HOLD;
      cnt_reg      <= '0;
      retry_reg    <= 2'd0;
      lock_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      retry_reg    <= retry_next;
      lock_err_reg <= lock_err_next;
    end
  end

  // Next-state logic; the counter is cleared on every state change.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    retry_next    = retry_reg;
    lock_err_next = lock_err_reg;
    ack_next      = 1'b0;
    capture       = 1'b0;
    case (state_reg)
      ST_RESET_HOLD: begin
        if (cnt_reg == RST_LAST) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          cnt_next   = '0;
          retry_next = (retry_inc > 3'd3) ? 2'd3 : retry_inc[1:0];
          if (int'(retry_inc) > MAX_RETRY) begin
            state_next    = ST_FAIL;
            lock_err_next = 1'b1;
          end else begin
            state_next = ST_RESET_HOLD;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = ST_READY;
          cnt_next   = '0;
          retry_next = 2'd0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_READY: begin
        // Lock loss takes priority; a pending request is served later.
        if (!lock_s) begin
          state_next = ST_RESET_HOLD;
          cnt_next   = '0;
        end else if (cfg_req) begin
          state_next = ST_RESET_HOLD;
          cnt_next   = '0;
          ack_next   = 1'b1;
          capture    = 1'b1;
        end
      end
      ST_FAIL: begin
        if (cfg_req) begin
          state_next    = ST_RESET_HOLD;
          cnt_next      = '0;
          ack_next      = 1'b1;
          capture       = 1'b1;
          lock_err_next = 1'b0;
          retry_next    = 2'd0;
        end
      end
      default: begin
        state_next = ST_RESET_HOLD;
        cnt_next   = '0;
      end
    endcase
  end

  // Registered control outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_reset_reg  <= 1'b1;
      pll_ready_reg  <= 1'b0;
      user_rst_n_reg <= 1'b0;
      cfg_ack_reg    <= 1'b0;
    end else begin
      pll_reset_reg  <= (state_next == ST_RESET_HOLD) || (state_next == ST_FAIL);
      pll_ready_reg  <= (state_next == ST_READY);
      user_rst_n_reg <= (state_next == ST_READY);
      cfg_ack_reg    <= ack_next;
    end
  end

  // Divider codes, captured on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idiv_reg  <= IDIV_RST;
      fbdiv_reg <= FBDIV_RST;
      odiv_reg  <= ODIV_RST;
    end else if (capture) begin
      idiv_reg  <= cfg_idiv;
      fbdiv_reg <= cfg_fbdiv;
      odiv_reg  <= cfg_odiv;
    end
  end

  // Select outputs only follow the codes while the PLL is held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idsel_reg  <= encode_sel(IDIV_RST);
      fbdsel_reg <= encode_sel(FBDIV_RST);
      odsel_reg  <= encode_sel(ODIV_RST);
    end else if (pll_reset_reg) begin
      idsel_reg  <= encode_sel(idiv_reg);
      fbdsel_reg <= encode_sel(fbdiv_reg);
      odsel_reg  <= encode_sel(odiv_reg);
    end
  end

  assign cfg_ack    = cfg_ack_reg;
  assign pll_reset  = pll_reset_reg;
  assign pll_idsel  = idsel_reg;
  assign pll_fbdsel = fbdsel_reg;
  assign pll_odsel  = odsel_reg;
  assign pll_ready  = pll_ready_reg;
  assign user_rst_n = user_rst_n_reg;
  assign lock_err   = lock_err_reg;
  assign retry_cnt  = retry_reg;
  assign state_o    = state_reg;

endmodule

// File: tb/tb_pll_supervisor.sv
// Scoreboard bench for pll_supervisor: the stimulus pushes the expected
// sequence of state transitions; a monitor pops one record per transition.
module tb_pll_supervisor;

  localparam logic [2:0] S_RH = 3'd0, S_WL = 3'd1, S_ST = 3'd2, S_RDY = 3'd3, S_FAIL = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_lock = 1'b0;
  logic       cfg_req = 1'b0;
  logic [5:0] cfg_idiv = 6'd0, cfg_fbdiv = 6'd0, cfg_odiv = 6'd0;
  logic       cfg_ack, pll_reset, pll_ready, user_rst_n, lock_err;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  pll_supervisor #(.LOCK_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .cfg_req(cfg_req),
    .cfg_idiv(cfg_idiv), .cfg_fbdiv(cfg_fbdiv), .cfg_odiv(cfg_odiv),
    .cfg_ack(cfg_ack), .pll_reset(pll_reset), .pll_idsel(pll_idsel),
    .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel), .pll_ready(pll_ready),
    .user_rst_n(user_rst_n), .lock_err(lock_err), .retry_cnt(retry_cnt),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    int         dwell;     // cycles spent in the previous state, -1 = don't care
    logic [1:0] retry;
    logic       lerr;
    logic       prst;
    logic       rdy;
    logic       ack;
    logic       chk_sel;
    logic [5:0] id, fb, od;
  } exp_t;

  exp_t sb[$];
  int errors = 0, checks = 0, cyc = 0, ack_seen = 0;

  function automatic logic [5:0] inv6(input logic [5:0] v);
    return ~v;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input logic [2:0] st, input int dwell, input logic [1:0] retry,
                      input logic lerr, input logic prst, input logic rdy, input logic ack,
                      input logic chk_sel, input logic [5:0] id, input logic [5:0] fb,
                      input logic [5:0] od);
    exp_t e;
    e.st = st; e.dwell = dwell; e.retry = retry; e.lerr = lerr; e.prst = prst;
    e.rdy = rdy; e.ack = ack; e.chk_sel = chk_sel; e.id = id; e.fb = fb; e.od = od;
    sb.push_back(e);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (state_o == s) return;
      n++;
      if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL timeout_%s: state %0d, expected %0d within %0d cycles", tag, state_o, s, budget);
        return;
      end
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, state_o, S_RH);
    chk({tag, "_pll_reset"}, pll_reset, 1);
    chk({tag, "_pll_ready"}, pll_ready, 0);
    chk({tag, "_user_rst_n"}, user_rst_n, 0);
    chk({tag, "_cfg_ack"}, cfg_ack, 0);
    chk({tag, "_lock_err"}, lock_err, 0);
    chk({tag, "_retry_cnt"}, retry_cnt, 0);
    chk({tag, "_idsel"}, pll_idsel, inv6(6'd6));
    chk({tag, "_fbdsel"}, pll_fbdsel, inv6(6'd12));
    chk({tag, "_odsel"}, pll_odsel, inv6(6'd8));
  endtask

  // Monitor: one scoreboard record per observed state transition.
  initial begin
    logic [2:0] prev_st;
    int last_cyc;
    exp_t e;
    prev_st = S_RH;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cfg_ack) ack_seen++;
      if (state_o != prev_st) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transition: got state %0d, expected no transition", state_o);
        end else begin
          e = sb.pop_front();
          $display("cycle %0d: state %0d -> %0d after %0d cycles, retry=%0d lock_err=%0d ack=%0d",
                   cyc, prev_st, state_o, cyc - last_cyc, retry_cnt, lock_err, cfg_ack);
          chk("state", state_o, e.st);
          if (e.dwell >= 0) chk("dwell", cyc - last_cyc, e.dwell);
          chk("retry_cnt", retry_cnt, e.retry);
          chk("lock_err", lock_err, e.lerr);
          chk("pll_reset", pll_reset, e.prst);
          chk("pll_ready", pll_ready, e.rdy);
          chk("user_rst_n", user_rst_n, e.rdy);
          chk("cfg_ack", cfg_ack, e.ack);
          if (e.chk_sel) begin
            chk("idsel", pll_idsel, inv6(e.id));
            chk("fbdsel", pll_fbdsel, inv6(e.fb));
            chk("odsel", pll_odsel, inv6(e.od));
          end
        end
        prev_st = state_o;
        last_cyc = cyc;
      end
      if (!rst_n) last_cyc = cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset with lock already present.
    #1 rst_n = 1'b0;
    pll_lock = 1'b1;
    #1 chk_reset_values("por");

    push(S_WL, 16, 2'd0, 0, 0, 0, 0, 1, 6'd6, 6'd12, 6'd8);
    push(S_ST, 1, 2'd0, 0, 0, 0, 0, 0, 6'd0, 6'd0, 6'd0);
    push(S_RDY, 1024, 2'd0, 0, 0, 1, 0, 0, 6'd0, 6'd0, 6'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_state(S_RDY, 1200, "ready1");

    // Reconfigure from READY with cfg_req held 5 cycles, then a lock glitch
    // at STABLE count 500.
    push(S_RH, -1, 2'd0, 0, 1, 0, 1, 0, 6'd0, 6'd0, 6'd0);
    push(S_WL, 16, 2'd0, 0, 0, 0, 0, 1, 6'd2, 6'd10, 6'd5);
    push(S_ST, 1, 2'd0, 0, 0, 0, 0, 0, 6'd0, 6'd0, 6'd0);
    push(S_WL, 503, 2'd0, 0, 0, 0, 0, 1, 6'd2, 6'd10, 6'd5);
    push(S_ST, 3, 2'd0, 0, 0, 0, 0, 0, 6'd0, 6'd0, 6'd0);
    push(S_RDY, 1024, 2'd0, 0, 0, 1, 0, 0, 6'd0, 6'd0, 6'd0);
    cfg_idiv = 6'd2; cfg_fbdiv = 6'd10; cfg_odiv = 6'd5;
    cfg_req = 1'b1;
    repeat (5) @(negedge clk);
    cfg_req = 1'b0;
    wait_state(S_ST, 40, "stable2");
    repeat (500) @(negedge clk);
    pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    pll_lock = 1'b1;
    wait_state(S_RDY, 1600, "ready2");

    // Lock stuck low: four timed-out attempts then FAIL.
    push(S_RH, -1, 2'd0, 0, 1, 0, 0, 0, 6'd0, 6'd0, 6'd0);
    for (int k = 0; k < 3; k++) begin
      push(S_WL, 16, 2'(k), 0, 0, 0, 0, 1, 6'd2, 6'd10, 6'd5);
      push(S_RH, 64, 2'(k + 1), 0, 1, 0, 0, 0, 6'd0, 6'd0, 6'd0);
    end
    push(S_WL, 16, 2'd3, 0, 0, 0, 0, 1, 6'd2, 6'd10, 6'd5);
    push(S_FAIL, 64, 2'd3, 1, 1, 0, 0, 0, 6'd0, 6'd0, 6'd0);
    pll_lock = 1'b0;
    wait_state(S_FAIL, 600, "fail");

    // Exit FAIL through a reconfiguration; lock comes back.
    push(S_RH, -1, 2'd0, 0, 1, 0, 1, 0, 6'd0, 6'd0, 6'd0);
    push(S_WL, 16, 2'd0, 0, 0, 0, 0, 1, 6'd3, 6'd20, 6'd4);
    push(S_ST, 1, 2'd0, 0, 0, 0, 0, 0, 6'd0, 6'd0, 6'd0);
    push(S_RDY, 1024, 2'd0, 0, 0, 1, 0, 0, 6'd0, 6'd0, 6'd0);
    pll_lock = 1'b1;
    cfg_idiv = 6'd3; cfg_fbdiv = 6'd20; cfg_odiv = 6'd4;
    cfg_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
    wait_state(S_RDY, 1200, "ready3");

    // Reconfigure, then assert rst_n while waiting for lock.
    push(S_RH, -1, 2'd0, 0, 1, 0, 1, 0, 6'd0, 6'd0, 6'd0);
    push(S_WL, 16, 2'd0, 0, 0, 0, 0, 1, 6'd1, 6'd30, 6'd2);
    push(S_RH, -1, 2'd0, 0, 1, 0, 0, 1, 6'd6, 6'd12, 6'd8);
    push(S_WL, 16, 2'd0, 0, 0, 0, 0, 1, 6'd6, 6'd12, 6'd8);
    push(S_ST, 1, 2'd0, 0, 0, 0, 0, 0, 6'd0, 6'd0, 6'd0);
    push(S_RDY, 1024, 2'd0, 0, 0, 1, 0, 0, 6'd0, 6'd0, 6'd0);
    cfg_idiv = 6'd1; cfg_fbdiv = 6'd30; cfg_odiv = 6'd2;
    cfg_req = 1'b1;
    pll_lock = 1'b0;
    @(negedge clk);
    cfg_req = 1'b0;
    wait_state(S_WL, 40, "wait_lock4");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    pll_lock = 1'b1;
    #1 chk_reset_values("midrst");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_state(S_RDY, 1200, "ready4");

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("ack_count", ack_seen, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
